// File: rtl/serial_frame_sender.sv
// UART command-frame transmitter: FF FF 00 len payload EE EE,
// with per-byte clear-to-send gating and configurable framing.
module serial_frame_sender #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int PARITY      = 1,
    parameter int STOP_BITS   = 1,
    parameter int GAP_BITS    = 3,
    parameter int MAX_PAYLOAD = 16,
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [7:0]    payload_len,
    input  logic          start,
    input  logic          cts,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD;
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [7:0] STOP_LAST = 8'(STOP_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);
    localparam logic [8:0] MAX_LEN = 9'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_START, S_DATA, S_PAR, S_STOP, S_GAP, S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic [TW-1:0]   r_tick, w_tick;
    logic [7:0]      r_bit, w_bit;
    logic [8:0]      r_idx, w_idx;
    logic [7:0]      r_len, w_len;
    logic            r_err, w_err;
    logic [7:0]      r_buf [MAX_PAYLOAD];

    logic [8:0]      w_len9;
    logic [8:0]      w_pidx;
    logic [7:0]      w_byte;
    logic            w_par;
    logic            w_last;
    logic            w_tick_end;

    assign w_len9     = {1'b0, r_len};
    assign w_pidx     = r_idx - 9'd4;
    assign w_last     = (r_idx == w_len9 + 9'd5);
    assign w_tick_end = (r_tick == '0);
    assign w_par      = (PARITY == 2) ? ~(^w_byte) : (^w_byte);

    always_comb begin
        w_byte = 8'hEE;
        if (r_idx < 9'd2)
            w_byte = 8'hFF;
        else if (r_idx == 9'd2)
            w_byte = 8'h00;
        else if (r_idx == 9'd3)
            w_byte = r_len;
        else if (r_idx < w_len9 + 9'd4 && w_pidx < MAX_LEN)
            w_byte = r_buf[w_pidx[AW-1:0]];
    end

    // End of a byte jumps straight to START when cts is already high,
    // so back-to-back start bits stay exactly one byte period apart.
    always_comb begin
        w_state = r_state;
        w_tick  = w_tick_end ? TICK_LAST : r_tick - TW'(1);
        w_bit   = r_bit;
        w_idx   = r_idx;
        w_len   = r_len;
        w_err   = 1'b0;
        tx      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_tick = TICK_LAST;
                if (start) begin
                    if (payload_len == 8'd0 || {1'b0, payload_len} > MAX_LEN) begin
                        w_err = 1'b1;
                    end else begin
                        w_len   = payload_len;
                        w_idx   = '0;
                        w_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_tick = TICK_LAST;
                if (cts)
                    w_state = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (w_tick_end) begin
                    w_state = S_DATA;
                    w_bit   = '0;
                end
            end
            S_DATA: begin
                tx = w_byte[r_bit[2:0]];
                if (w_tick_end) begin
                    w_bit = r_bit + 8'd1;
                    if (r_bit == 8'd7) begin
                        w_bit   = '0;
                        w_state = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                tx = w_par;
                if (w_tick_end) begin
                    w_state = S_STOP;
                    w_bit   = '0;
                end
            end
            S_STOP: begin
                if (w_tick_end) begin
                    w_bit = r_bit + 8'd1;
                    if (r_bit == STOP_LAST) begin
                        w_bit = '0;
                        if (w_last) begin
                            w_state = S_DONE;
                        end else if (GAP_BITS == 0) begin
                            w_idx   = r_idx + 9'd1;
                            w_state = cts ? S_START : S_WAIT;
                        end else begin
                            w_state = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_tick_end) begin
                    w_bit = r_bit + 8'd1;
                    if (r_bit == GAP_LAST) begin
                        w_bit   = '0;
                        w_idx   = r_idx + 9'd1;
                        w_state = cts ? S_START : S_WAIT;
                    end
                end
            end
            S_DONE: begin
                w_tick  = TICK_LAST;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= TICK_LAST;
            r_bit   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_idx   <= w_idx;
            r_len   <= w_len;
            r_err   <= w_err;
        end
    end

    // Payload buffer keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en && r_state == S_IDLE && 32'(wr_addr) < MAX_PAYLOAD)
            r_buf[wr_addr] <= wr_data;
    end

    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);
    assign err  = r_err;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Directed bench for serial_frame_sender: line decoder plus
// hand-computed byte/parity tables, timing and handshake checks.
module tb_serial_frame_sender;

    localparam int T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    logic       sel;
    logic       line;

    logic       wr_en_a, start_a, cts_a, tx_a, busy_a, done_a, err_a;
    logic [3:0] wr_addr_a;
    logic [7:0] wr_data_a, payload_len_a;
    logic       wr_en_b, start_b, cts_b, tx_b, busy_b, done_b, err_b;
    logic [3:0] wr_addr_b;
    logic [7:0] wr_data_b, payload_len_b;

    serial_frame_sender #(
        .CLK_FREQ(1000000), .BAUD(125000), .PARITY(1),
        .STOP_BITS(1), .GAP_BITS(3), .MAX_PAYLOAD(16)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .payload_len(payload_len_a), .start(start_a),
        .cts(cts_a), .tx(tx_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    serial_frame_sender #(
        .CLK_FREQ(1000000), .BAUD(125000), .PARITY(2),
        .STOP_BITS(2), .GAP_BITS(0), .MAX_PAYLOAD(16)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .payload_len(payload_len_b), .start(start_b),
        .cts(cts_b), .tx(tx_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    assign line = sel ? tx_b : tx_a;

    int n_vec = 0;
    int n_bad = 0;
    int dn_a = 0, dn_b = 0, tdn_a = -1, tdn_b = -1;

    always @(negedge clk) begin
        if (done_a) begin dn_a++; tdn_a = cyc; end
        if (done_b) begin dn_b++; tdn_b = cyc; end
    end

    logic [7:0] g_d [16];
    logic       g_p [16];
    int         g_t [16];
    logic [7:0] e_d [16];
    logic       e_p [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        if (sel) begin wr_en_b = 1; wr_addr_b = a; wr_data_b = d; end
        else     begin wr_en_a = 1; wr_addr_a = a; wr_data_a = d; end
        tick(1);
        wr_en_a = 0;
        wr_en_b = 0;
    endtask

    task automatic go(input logic [7:0] len, output int c);
        c = cyc;
        if (sel) begin payload_len_b = len; start_b = 1; end
        else     begin payload_len_a = len; start_a = 1; end
        tick(1);
        start_a = 0;
        start_b = 0;
    endtask

    task automatic rx_byte(input int par_en, input int nstop,
                           output logic [7:0] d, output logic p, output int tf);
        int k;
        k  = 0;
        d  = '0;
        p  = 1'b0;
        tf = -1;
        while (line !== 1'b0 && k < 20000) begin tick(1); k++; end
        if (line !== 1'b0) begin
            chk("rx_timeout", line, 0);
            return;
        end
        tf = cyc;
        tick(T / 2);
        chk("start_bit", line, 0);
        for (int i = 0; i < 8; i++) begin tick(T); d[i] = line; end
        if (par_en != 0) begin tick(T); p = line; end
        for (int i = 0; i < nstop; i++) begin tick(T); chk("stop_bit", line, 1); end
    endtask

    task automatic rx_frame(input int n, input int par_en, input int nstop);
        for (int i = 0; i < n; i++)
            rx_byte(par_en, nstop, g_d[i], g_p[i], g_t[i]);
    endtask

    task automatic load_exp(input logic [127:0] bv, input logic [15:0] pv, input int n);
        for (int i = 0; i < n; i++) begin
            e_d[i] = bv[8*(n-1-i) +: 8];
            e_p[i] = pv[n-1-i];
        end
    endtask

    task automatic chk_frame(input string tag, input int n, input int sp);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), g_d[i], e_d[i]);
            chk($sformatf("%s_par%0d", tag, i), g_p[i], e_p[i]);
            if (i > 0 && sp > 0)
                chk($sformatf("%s_gap%0d", tag, i), g_t[i] - g_t[i-1], sp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t0, tr, lows, k;
        rst_n = 0; sel = 0;
        wr_en_a = 0; wr_addr_a = 0; wr_data_a = 0; payload_len_a = 0; start_a = 0; cts_a = 1;
        wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0; payload_len_b = 0; start_b = 0; cts_b = 1;
        tick(3);
        chk("rst_tx", tx_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        rst_n = 1;
        tick(2);

        // Frame 1: payload 02 03, even parity
        wr(4'd0, 8'h02);
        wr(4'd1, 8'h03);
        go(8'd2, t0);
        chk("lat_busy", busy_a, 1);
        chk("lat_tx_idle", tx_a, 1);
        rx_frame(8, 1, 1);
        chk("lat_fall", g_t[0], t0 + 2);
        load_exp(128'hFFFF00020203EEEE, 16'b00011000, 8);
        chk_frame("f1", 8, 14 * T);
        tick(24);
        chk("f1_done_cnt", dn_a, 1);
        chk("f1_done_t", tdn_a, g_t[0] + 8 * 14 * T - 3 * T);
        chk("f1_busy_low", busy_a, 0);

        // Rejected lengths
        payload_len_a = 8'd0; start_a = 1; tick(1); start_a = 0;
        chk("err0_pulse", err_a, 1);
        chk("err0_busy", busy_a, 0);
        tick(1);
        chk("err0_clear", err_a, 0);
        chk("err0_tx", tx_a, 1);
        payload_len_a = 8'd17; start_a = 1; tick(1); start_a = 0;
        chk("err17_pulse", err_a, 1);
        chk("err17_busy", busy_a, 0);
        tick(1);
        chk("err17_clear", err_a, 0);
        chk("err17_tx", tx_a, 1);

        // CTS held low after the third byte
        go(8'd2, t0);
        for (int i = 0; i < 3; i++) rx_byte(1, 1, g_d[i], g_p[i], g_t[i]);
        cts_a = 0;
        lows = 0;
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if (tx_a !== 1'b1) lows++;
        end
        chk("hold_tx_high", lows, 0);
        cts_a = 1;
        tr = cyc;
        for (int i = 3; i < 8; i++) rx_byte(1, 1, g_d[i], g_p[i], g_t[i]);
        chk("cts_resume", g_t[3], tr + 1);
        chk_frame("f2", 8, 0);
        tick(24);
        chk("f2_done_cnt", dn_a, 2);

        // Reset during the payload, then a clean frame
        go(8'd2, t0);
        for (int i = 0; i < 4; i++) rx_byte(1, 1, g_d[i], g_p[i], g_t[i]);
        k = 0;
        while (tx_a !== 1'b0 && k < 200) begin tick(1); k++; end
        tick(2);
        chk("pre_rst_low", tx_a, 0);
        #3 rst_n = 0;
        #1;
        chk("rst_tx_now", tx_a, 1);
        chk("rst_busy_now", busy_a, 0);
        tick(2);
        rst_n = 1;
        tick(200);
        chk("abort_no_done", dn_a, 2);
        go(8'd2, t0);
        rx_frame(8, 1, 1);
        chk_frame("f3", 8, 14 * T);
        tick(24);
        chk("f3_done_cnt", dn_a, 3);

        // Write and restart while busy are ignored
        go(8'd1, t0);
        payload_len_a = 8'd3;
        start_a = 1;
        wr(4'd0, 8'h55);
        start_a = 0;
        rx_frame(7, 1, 1);
        load_exp(128'hFFFF000102EEEE, 16'b0001100, 7);
        chk_frame("f4", 7, 14 * T);
        tick(24);
        chk("f4_done_cnt", dn_a, 4);
        go(8'd1, t0);
        rx_frame(7, 1, 1);
        chk_frame("f5", 7, 14 * T);
        tick(24);
        chk("f5_done_cnt", dn_a, 5);

        // Odd parity, two stop bits, no gap
        sel = 1;
        wr(4'd0, 8'hA5);
        go(8'd1, t0);
        rx_frame(7, 1, 2);
        chk("b_lat_fall", g_t[0], t0 + 2);
        load_exp(128'hFFFF0001A5EEEE, 16'b1110111, 7);
        chk_frame("fb", 7, 12 * T);
        tick(24);
        chk("fb_done_cnt", dn_b, 1);
        chk("fb_done_t", tdn_b, g_t[0] + 7 * 12 * T);
        chk("fb_busy_low", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
